// File: rtl/modexp_ctrl_sc.sv
// Constant-time left-to-right square-and-multiply sequencer driving a modmult_sc multiplier.
// Optional macro MODEXP_PUBLIC_EARLY_EXIT_EN shortens runs whose exponent is labelled public.
module modexp_ctrl_sc #(
  parameter int unsigned MPWID  = 32,
  parameter int unsigned EXPWID = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MPWID-1:0]  base,
  input  logic [EXPWID-1:0] exponent,
  input  logic [MPWID-1:0]  modulus,
  input  logic              base_label,
  input  logic              exp_label,
  input  logic              modulus_label,
  output logic [MPWID-1:0]  result,
  output logic              result_label,
  output logic              busy,
  output logic              done,
  output logic              mm_ds,
  output logic [MPWID-1:0]  mm_mpand,
  output logic [MPWID-1:0]  mm_mplier,
  output logic [MPWID-1:0]  mm_modulus,
  output logic              mm_mpand_label,
  output logic              mm_mplier_label,
  output logic              mm_modulus_label,
  input  logic              mm_ready,
  input  logic [MPWID-1:0]  mm_product
);

  localparam int unsigned IDXW = (EXPWID > 1) ? $clog2(EXPWID) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQ_ISSUE  = 3'd1,
    SQ_WAIT   = 3'd2,
    MUL_ISSUE = 3'd3,
    MUL_WAIT  = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [MPWID-1:0]  base_q, base_d;
  logic [EXPWID-1:0] exp_q, exp_d;
  logic [MPWID-1:0]  mod_q, mod_d;
  logic              bl_q, bl_d, el_q, el_d, ml_q, ml_d;
  logic [MPWID-1:0]  acc_q, acc_d;
  logic              acc_label_q, acc_label_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [MPWID-1:0]  result_d;
  logic              result_label_d, busy_d, done_d, mm_ds_d;
  logic [MPWID-1:0]  mm_mpand_d, mm_mplier_d, mm_modulus_d;
  logic              mm_mpand_label_d, mm_mplier_label_d, mm_modulus_label_d;

`ifdef MODEXP_PUBLIC_EARLY_EXIT_EN
  function automatic logic [IDXW-1:0] msb_index(input logic [EXPWID-1:0] e);
    logic [IDXW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < EXPWID; k++) begin
      if (e[k]) r = IDXW'(k);
    end
    return r;
  endfunction
`endif

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d            = state_q;
    base_d             = base_q;
    exp_d              = exp_q;
    mod_d              = mod_q;
    bl_d               = bl_q;
    el_d               = el_q;
    ml_d               = ml_q;
    acc_d              = acc_q;
    acc_label_d        = acc_label_q;
    idx_d              = idx_q;
    result_d           = result;
    result_label_d     = result_label;
    done_d             = 1'b0;
    mm_ds_d            = 1'b0;
    mm_mpand_d         = mm_mpand;
    mm_mplier_d        = mm_mplier;
    mm_modulus_d       = mm_modulus;
    mm_mpand_label_d   = mm_mpand_label;
    mm_mplier_label_d  = mm_mplier_label;
    mm_modulus_label_d = mm_modulus_label;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base;
          exp_d       = exponent;
          mod_d       = modulus;
          bl_d        = base_label;
          el_d        = exp_label;
          ml_d        = modulus_label;
          acc_d       = MPWID'(1);
          acc_label_d = 1'b0;
          idx_d       = IDXW'(EXPWID - 1);
          state_d     = SQ_ISSUE;
`ifdef MODEXP_PUBLIC_EARLY_EXIT_EN
          if (!exp_label) begin
            if (exponent == '0) begin
              acc_d   = (modulus == MPWID'(1)) ? '0 : MPWID'(1);
              state_d = DONE;
            end else begin
              idx_d = msb_index(exponent);
            end
          end
`endif
        end
      end
      SQ_ISSUE: state_d = SQ_WAIT;
      SQ_WAIT: begin
        if (mm_ready) begin
          acc_d   = mm_product;
          state_d = MUL_ISSUE;
        end
      end
      MUL_ISSUE: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mm_ready) begin
          // Exponent bit only steers a data mux; the control path is identical for 0 and 1.
          acc_d       = exp_q[idx_q] ? mm_product : acc_q;
          acc_label_d = bl_q | el_q | ml_q;
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDXW'(1);
            state_d = SQ_ISSUE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Operands are loaded on entry to an issue state and held until the next issue.
    if (state_d == SQ_ISSUE) begin
      mm_ds_d            = 1'b1;
      mm_mpand_d         = acc_d;
      mm_mplier_d        = acc_d;
      mm_modulus_d       = mod_d;
      mm_mpand_label_d   = acc_label_d;
      mm_mplier_label_d  = acc_label_d;
      mm_modulus_label_d = ml_d;
    end else if (state_d == MUL_ISSUE) begin
      mm_ds_d            = 1'b1;
      mm_mpand_d         = acc_d;
      mm_mplier_d        = base_d;
      mm_modulus_d       = mod_d;
      mm_mpand_label_d   = acc_label_d;
      mm_mplier_label_d  = bl_d;
      mm_modulus_label_d = ml_d;
    end

    if (state_q == DONE) begin
      result_d       = acc_q;
      result_label_d = bl_q | el_q | ml_q;
      done_d         = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      base_q           <= '0;
      exp_q            <= '0;
      mod_q            <= '0;
      bl_q             <= 1'b0;
      el_q             <= 1'b0;
      ml_q             <= 1'b0;
      acc_q            <= MPWID'(1);
      acc_label_q      <= 1'b0;
      idx_q            <= '0;
      result           <= '0;
      result_label     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mm_ds            <= 1'b0;
      mm_mpand         <= '0;
      mm_mplier        <= '0;
      mm_modulus       <= '0;
      mm_mpand_label   <= 1'b0;
      mm_mplier_label  <= 1'b0;
      mm_modulus_label <= 1'b0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      exp_q            <= exp_d;
      mod_q            <= mod_d;
      bl_q             <= bl_d;
      el_q             <= el_d;
      ml_q             <= ml_d;
      acc_q            <= acc_d;
      acc_label_q      <= acc_label_d;
      idx_q            <= idx_d;
      result           <= result_d;
      result_label     <= result_label_d;
      busy             <= busy_d;
      done             <= done_d;
      mm_ds            <= mm_ds_d;
      mm_mpand         <= mm_mpand_d;
      mm_mplier        <= mm_mplier_d;
      mm_modulus       <= mm_modulus_d;
      mm_mpand_label   <= mm_mpand_label_d;
      mm_mplier_label  <= mm_mplier_label_d;
      mm_modulus_label <= mm_modulus_label_d;
    end
  end

endmodule
